i_cache_refill_ctrl: RTL

Refill controller that sits directly upstream of the instruction cache slice.
- On a cache miss (fetch address outside the slice's base/bound window), fetches a full aligned window of words from backing memory over a valid/ready request port and an in-order response port.
- Writes each returned word into the slice through its refill port, then reprograms the slice's base and bound registers.
- Stalls the CPU fetch stage for the whole operation.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/i_cache_refill_ctrl_req_issuer.sv | 54 +++++
 rtl/i_cache_refill_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache refill controller.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    SET_BASE  = 2'd2,
    SET_BOUND = 2'd3
  } refill_state_t;

  localparam int WORD_BYTES = 4;

  // Align a byte address down to the start of a cache_words-sized window.
  function automatic logic [31:0] win_align(input logic [31:0] addr, input int cache_words);
    logic [31:0] mask;
    mask = 32'(cache_words * WORD_BYTES) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/i_cache_refill_ctrl_req_issuer.sv
// Memory read request issuer: walks the refill window word by word while
// keeping the number of unanswered requests under MAX_OUTSTANDING.
module refill_req_issuer
  import icache_pkg::*;
#(
  parameter int CACHE_WORDS     = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = $clog2(CACHE_WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          active_i,
  input  logic [CW-1:0] rsp_cnt_i,
  input  logic [31:0]   win_base_i,
  input  logic          req_ready_i,
  output logic          req_valid_o,
  output logic [31:0]   req_addr_o,
  output logic [CW-1:0] req_cnt_o
);

  logic [CW-1:0] req_cnt_q, req_cnt_d;
  logic [CW-1:0] in_flight;

  // rsp_cnt never passes req_cnt, so the difference is the in-flight count.
  assign in_flight = req_cnt_q - rsp_cnt_i;

  // Valid and address derive only from registered state; rsp_cnt can only
  // grow, so a raised valid cannot drop before it is accepted.
  always_comb begin
    req_valid_o = active_i
                && (req_cnt_q < CW'(CACHE_WORDS))
                && (32'(in_flight) < 32'(MAX_OUTSTANDING));
    req_addr_o  = win_base_i + 32'(req_cnt_q) * 32'(WORD_BYTES);
  end

  // Next request index: cleared at refill start, advanced on each handshake.
  always_comb begin
    req_cnt_d = req_cnt_q;
    if (clear_i)
      req_cnt_d = '0;
    else if (req_valid_o && req_ready_i)
      req_cnt_d = req_cnt_q + CW'(1);
  end

  // Request counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) req_cnt_q <= '0;
    else        req_cnt_q <= req_cnt_d;
  end

  assign req_cnt_o = req_cnt_q;

endmodule

// File: rtl/i_cache_refill_ctrl.sv
// Instruction-cache refill controller: on a miss, fetches the aligned window
// from memory, streams it into the cache slice, then reprograms base/bound.
module i_cache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int CACHE_WORDS     = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_address,
  input  logic        i_cache_miss,
  output logic        cpu_stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        refill_enable,
  output logic [31:0] refill_address,
  output logic [31:0] refill_data,
  output logic [31:0] set_base_addr,
  output logic [31:0] set_bound_addr,
  output logic        base_addr_we,
  output logic        bound_addr_we,
  output logic [31:0] refill_count
);

  localparam int CW = $clog2(CACHE_WORDS) + 1;
  localparam logic [31:0] WIN_LAST = 32'(CACHE_WORDS * WORD_BYTES) - 32'(WORD_BYTES);

  refill_state_t state_q, state_d;
  logic [31:0]   win_base_q, win_base_d;
  logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [CW-1:0] req_cnt;
  logic          start;
  logic          rsp_take;
  logic          refill_en_q;
  logic [31:0]   refill_addr_q, refill_data_q;
  logic [31:0]   refill_count_q;

  refill_req_issuer #(
    .CACHE_WORDS    (CACHE_WORDS),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CW             (CW)
  ) u_issuer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start),
    .active_i   (state_q == FILL),
    .rsp_cnt_i  (rsp_cnt_q),
    .win_base_i (win_base_q),
    .req_ready_i(mem_req_ready),
    .req_valid_o(mem_req_valid),
    .req_addr_o (mem_req_addr),
    .req_cnt_o  (req_cnt)
  );

  // A response with nothing in flight is a protocol error and is dropped;
  // responses outside FILL (e.g. after a reset) are ignored entirely.
  assign rsp_take = (state_q == FILL) && mem_rsp_valid && (rsp_cnt_q != req_cnt);

  // Next-state logic. Leaving FILL uses the next response count so the last
  // refill strobe lines up with the SET_BASE cycle.
  always_comb begin
    state_d    = state_q;
    win_base_d = win_base_q;
    rsp_cnt_d  = rsp_cnt_q;
    start      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cache_miss) begin
          state_d    = FILL;
          win_base_d = win_align(fetch_address, CACHE_WORDS);
          rsp_cnt_d  = '0;
          start      = 1'b1;
        end
      end
      FILL: begin
        if (rsp_take) rsp_cnt_d = rsp_cnt_q + CW'(1);
        if (rsp_cnt_d == CW'(CACHE_WORDS)) state_d = SET_BASE;
      end
      SET_BASE:  state_d = SET_BOUND;
      SET_BOUND: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM, window base and response counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_base_q <= '0;
      rsp_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      win_base_q <= win_base_d;
      rsp_cnt_q  <= rsp_cnt_d;
    end
  end

  // Register each accepted response into a one-cycle slice write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refill_en_q   <= 1'b0;
      refill_addr_q <= '0;
      refill_data_q <= '0;
    end else begin
      refill_en_q <= rsp_take;
      if (rsp_take) begin
        refill_addr_q <= 32'(rsp_cnt_q);
        refill_data_q <= mem_rsp_data;
      end
    end
  end

  // Completed-refill counter, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n)
      refill_count_q <= '0;
    else if ((state_q == SET_BOUND) && (refill_count_q != 32'hFFFF_FFFF))
      refill_count_q <= refill_count_q + 32'd1;
  end

  // Base and bound go out in separate cycles since the slice favours base.
  always_comb begin
    base_addr_we   = (state_q == SET_BASE);
    bound_addr_we  = (state_q == SET_BOUND);
    set_base_addr  = base_addr_we  ? win_base_q : '0;
    set_bound_addr = bound_addr_we ? (win_base_q + WIN_LAST) : '0;
  end

  assign cpu_stall      = (state_q != IDLE) || i_cache_miss;
  assign refill_enable  = refill_en_q;
  assign refill_address = refill_addr_q;
  assign refill_data    = refill_data_q;
  assign refill_count   = refill_count_q;

endmodule
